score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9: points that end the game; legal range 1..15.
REQ-002 SHALL have parameter POINT_FRAMES, default 60: frame_tick count the ball stays frozen after a point; legal range 1..255.
REQ-003 SHALL have parameter SERVE_FRAMES, default 120: frame_tick count before an automatic serve; used only with AUTO_SERVE_EN.
REQ-004 SHALL have port clk_100MHz  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port start  input  1  debounced start/serve button, level.
REQ-008 SHALL have port goal1  input  1  one-cycle pulse: ball passed player 2's paddle (point to player 1).
REQ-009 SHALL have port goal2  input  1  one-cycle pulse: ball passed player 1's paddle (point to player 2).
REQ-010 SHALL have port player1_score  output  4  player 1 points, feeds the seven-segment display.
REQ-011 SHALL have port player2_score  output  4  player 2 points, feeds the seven-segment display.
REQ-012 SHALL have port ball_run  output  1  ball motion enable, fed to the pixel generator.
REQ-013 SHALL have port ball_reset  output  1  one-cycle pulse: recentre the ball.
REQ-014 SHALL have port serve_dir  output  1  initial ball direction (0 = toward player 1, 1 = toward player 2).
REQ-015 SHALL have port game_over  output  1  high while in OVER.
REQ-016 SHALL have port winner  output  1  0 = player 1, 1 = player 2; valid while game_over is high.

Function
REQ-017 SHALL use a rising-edge detector on start; "start edge" below means start is 1 this cycle and 0 the previous cycle.
REQ-018 SHALL implement states IDLE, SERVE, PLAY, POINT, OVER.
REQ-019 IDLE: ball_run = 0; on a start edge, pulse ball_reset and go to SERVE.
REQ-020 SERVE: ball_run = 0; on a start edge, go to PLAY next cycle with ball_run = 1.
REQ-021 PLAY: ball_run = 1; goal1 alone SHALL increment player1_score, set serve_dir = 0 and go to POINT.
REQ-022 PLAY: goal2 alone SHALL increment player2_score, set serve_dir = 1 and go to POINT.
REQ-023 PLAY: goal1 and goal2 in the same cycle SHALL change no score, pulse ball_reset and go to SERVE.
REQ-024 Score SHALL update in the cycle after the goal pulse; ball_run SHALL be 0 from that same cycle.
REQ-025 POINT: ball_run = 0; count frame_tick pulses; at the POINT_FRAMES-th pulse, go to OVER if either score equals WIN_SCORE, otherwise pulse ball_reset and go to SERVE.
REQ-026 OVER: game_over = 1; winner = 1 if player2_score equals WIN_SCORE, else 0; scores hold.
REQ-027 OVER: on a start edge, clear both scores, set serve_dir = 0, pulse ball_reset, and go to SERVE.
REQ-028 goal1/goal2 outside PLAY SHALL be ignored; a score SHALL never exceed WIN_SCORE.
REQ-029 frame_tick outside POINT (and outside SERVE when AUTO_SERVE_EN is defined) SHALL be ignored.
REQ-030 The frame counter SHALL clear on every state entry.
REQ-031 ball_reset SHALL be high for exactly one cycle per triggering event.

Reset
REQ-032 While reset is 0: state = IDLE, both scores = 0, ball_run = 0, ball_reset = 0, serve_dir = 0, game_over = 0, winner = 0, frame counter = 0, edge-detector history = 1.
REQ-033 Reset asserted in any state, including mid-count in POINT, SHALL abandon the operation with no residual pulse after release.
REQ-034 Because the edge-detector history resets to 1, a start held through reset release SHALL NOT count as an edge.

Configuration
REQ-035 Macro AUTO_SERVE_EN, when defined: SERVE also counts frame_tick, and at the SERVE_FRAMES-th pulse goes to PLAY exactly as on a start edge; the start edge also remains effective.
REQ-036 Without AUTO_SERVE_EN: SERVE leaves only on a start edge and does not count frame_tick.

Verification
REQ-037 Release reset with start = 1 held, then keep it high 10 cycles -> state stays IDLE, ball_reset never pulses.
REQ-038 Start edge, start edge, then goal1 -> player1_score 0->1 the next cycle, ball_run = 0, serve_dir = 0; after 60 frame_ticks -> one ball_reset pulse, state SERVE.
REQ-039 goal1 and goal2 in the same PLAY cycle -> both scores unchanged, one ball_reset pulse, state SERVE.
REQ-040 WIN_SCORE = 3, three goal2 points -> after the third POINT delay, game_over = 1, winner = 1, player2_score = 3; start edge -> scores 0/0, SERVE.
REQ-041 Reset pulsed during POINT after 30 ticks -> all outputs at reset values; goal1 while in IDLE is ignored.
REQ-042 With AUTO_SERVE_EN and SERVE_FRAMES = 4, no start -> PLAY, ball_run = 1, after the 4th frame_tick in SERVE.

Source files
------------

// File: rtl/score_keeper.sv
// Pong score keeper: serve/play/point/game-over sequencing with per-player scores.
// Optional macro AUTO_SERVE_EN: SERVE also auto-serves after SERVE_FRAMES frame ticks.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int POINT_FRAMES = 60,
  parameter int SERVE_FRAMES = 120
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal1,
  input  logic       goal2,
  output logic [3:0] player1_score,
  output logic [3:0] player2_score,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  // One counter serves both the point hold-off and the optional auto-serve delay.
  localparam int MAX_FRAMES = (POINT_FRAMES > SERVE_FRAMES) ? POINT_FRAMES : SERVE_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
`ifdef AUTO_SERVE_EN
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
`endif

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  state_t           state, state_nxt;
  logic             start_q;
  logic             start_edge;
  logic [CNT_W-1:0] frame_cnt;
  logic             inc1, inc2, clr_scores;
  logic             pulse, dir_nxt, count_en, go;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_nxt  = state;
    inc1       = 1'b0;
    inc2       = 1'b0;
    clr_scores = 1'b0;
    pulse      = 1'b0;
    dir_nxt    = serve_dir;
    count_en   = 1'b0;
    go         = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          pulse     = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
`ifdef AUTO_SERVE_EN
        count_en = 1'b1;
        go       = start_edge | (frame_tick & (frame_cnt == SERVE_LAST));
`else
        go       = start_edge;
`endif
        if (go) state_nxt = PLAY;
      end
      PLAY: begin
        if (goal1 && goal2) begin
          pulse     = 1'b1;
          state_nxt = SERVE;
        end else if (goal1) begin
          inc1      = 1'b1;
          dir_nxt   = 1'b0;
          state_nxt = POINT;
        end else if (goal2) begin
          inc2      = 1'b1;
          dir_nxt   = 1'b1;
          state_nxt = POINT;
        end
      end
      POINT: begin
        count_en = 1'b1;
        if (frame_tick && frame_cnt == POINT_LAST) begin
          if (player1_score == WIN || player2_score == WIN) begin
            state_nxt = OVER;
          end else begin
            pulse     = 1'b1;
            state_nxt = SERVE;
          end
        end
      end
      OVER: begin
        if (start_edge) begin
          clr_scores = 1'b1;
          dir_nxt    = 1'b0;
          pulse      = 1'b1;
          state_nxt  = SERVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge-detector history resets to 1 so a start held through reset is not an edge.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      start_q       <= 1'b1;
      ball_reset    <= 1'b0;
      serve_dir     <= 1'b0;
      player1_score <= '0;
      player2_score <= '0;
      frame_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      start_q    <= start;
      ball_reset <= pulse;
      serve_dir  <= dir_nxt;
      if (clr_scores) begin
        player1_score <= '0;
        player2_score <= '0;
      end else begin
        if (inc1 && player1_score != WIN) player1_score <= player1_score + 4'd1;
        if (inc2 && player2_score != WIN) player2_score <= player2_score + 4'd1;
      end
      if (state_nxt != state)         frame_cnt <= '0;
      else if (count_en && frame_tick) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign ball_run  = (state == PLAY);
  assign game_over = (state == OVER);
  assign winner    = game_over & (player2_score == WIN);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed game scenarios plus random play
// compared every cycle against a behavioural game model.
module tb_score_keeper;
  localparam int WIN = 3;
  localparam int PF  = 60;
  localparam int SF  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, goal1 = 1'b0, goal2 = 1'b0;
  logic [3:0] player1_score, player2_score;
  logic       ball_run, ball_reset, serve_dir, game_over, winner;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(WIN), .POINT_FRAMES(PF), .SERVE_FRAMES(SF)) dut (
    .clk_100MHz(clk), .reset(rst_n), .frame_tick(frame_tick), .start(start),
    .goal1(goal1), .goal2(goal2), .player1_score(player1_score),
    .player2_score(player2_score), .ball_run(ball_run), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Game model: phase of play plus scores, described directly from the game rules.
  string m_phase;
  int    m_s1, m_s2, m_ticks;
  bit    m_dir, m_hist, m_pulse;

  task automatic model_reset();
    m_phase = "idle"; m_s1 = 0; m_s2 = 0; m_ticks = 0;
    m_dir = 0; m_hist = 1; m_pulse = 0;
  endtask

  task automatic model_step(input bit st, input bit g1, input bit g2, input bit tk);
    bit    pressed;
    bit    counting;
    string nxt;
    pressed  = st && !m_hist;
    m_hist   = st;
    m_pulse  = 0;
    counting = 0;
    nxt      = m_phase;
    if (m_phase == "idle") begin
      if (pressed) begin m_pulse = 1; nxt = "serve"; end
    end else if (m_phase == "serve") begin
`ifdef AUTO_SERVE_EN
      counting = 1;
      if (pressed || (tk && m_ticks + 1 == SF)) nxt = "play";
`else
      if (pressed) nxt = "play";
`endif
    end else if (m_phase == "play") begin
      if (g1 && g2) begin
        m_pulse = 1; nxt = "serve";
      end else if (g1) begin
        m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1; m_dir = 0; nxt = "point";
      end else if (g2) begin
        m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2; m_dir = 1; nxt = "point";
      end
    end else if (m_phase == "point") begin
      counting = 1;
      if (tk && m_ticks + 1 == PF) begin
        if (m_s1 == WIN || m_s2 == WIN) nxt = "over";
        else begin m_pulse = 1; nxt = "serve"; end
      end
    end else if (m_phase == "over") begin
      if (pressed) begin
        m_s1 = 0; m_s2 = 0; m_dir = 0; m_pulse = 1; nxt = "serve";
      end
    end
    if (nxt != m_phase)      m_ticks = 0;
    else if (counting && tk) m_ticks++;
    m_phase = nxt;
  endtask

  function automatic logic [12:0] exp_vec();
    return {4'(m_s1), 4'(m_s2), m_phase == "play", m_pulse, m_dir,
            m_phase == "over", (m_phase == "over") && (m_s2 == WIN)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {player1_score, player2_score, ball_run, ball_reset, serve_dir, game_over, winner};
  endfunction

  task automatic cycle(input bit st, input bit g1, input bit g2, input bit tk, input string tag);
    start = st; goal1 = g1; goal2 = g2; frame_tick = tk;
    @(posedge clk);
    model_step(st, g1, g2, tk);
    #1;
    check(tag, 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic do_reset(input bit st);
    rst_n = 1'b0;
    start = st; goal1 = 1'b0; goal2 = 1'b0; frame_tick = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit st;
    #3;
    // Start held through reset release must not register as an edge.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, "held_start");
      check("held_start_no_pulse", 32'(ball_reset), 32'd0);
    end

    cycle(0, 0, 0, 0, "release");
    cycle(1, 0, 0, 0, "idle_to_serve");
    check("idle_edge_pulse", 32'(ball_reset), 32'd1);
    cycle(0, 0, 0, 0, "serve_wait");
    check("pulse_one_cycle", 32'(ball_reset), 32'd0);
    cycle(1, 0, 0, 0, "serve_to_play");
    check("play_run", 32'(ball_run), 32'd1);
    cycle(0, 1, 0, 0, "goal1");
    check("goal1_score", 32'(player1_score), 32'd1);
    check("goal1_run_off", 32'(ball_run), 32'd0);
    check("goal1_dir", 32'(serve_dir), 32'd0);
    for (int i = 0; i < PF - 1; i++) cycle(0, 0, 0, 1, "point_wait");
    check("point_no_early_pulse", 32'(ball_reset), 32'd0);
    cycle(0, 0, 0, 1, "point_end");
    check("point_end_pulse", 32'(ball_reset), 32'd1);
    cycle(0, 0, 0, 0, "after_point");

    // Simultaneous goals: no score change, re-serve.
    cycle(1, 0, 0, 0, "serve_to_play2");
    cycle(0, 1, 1, 0, "double_goal");
    check("double_goal_p1", 32'(player1_score), 32'd1);
    check("double_goal_p2", 32'(player2_score), 32'd0);
    check("double_goal_pulse", 32'(ball_reset), 32'd1);
    cycle(0, 0, 0, 0, "double_goal_after");
    cycle(1, 0, 0, 0, "reserve");
    check("reserve_run", 32'(ball_run), 32'd1);

    // Player 2 wins to WIN points.
    for (int p = 0; p < WIN; p++) begin
      if (p > 0) begin
        cycle(0, 0, 0, 0, "p2_serve_rel");
        cycle(1, 0, 0, 0, "p2_serve");
      end
      cycle(0, 0, 1, 0, "goal2");
      check("goal2_dir", 32'(serve_dir), 32'd1);
      for (int i = 0; i < PF; i++) cycle(0, 0, 0, 1, "p2_point_wait");
    end
    check("game_over", 32'(game_over), 32'd1);
    check("winner_p2", 32'(winner), 32'd1);
    check("p2_final", 32'(player2_score), 32'(WIN));
    cycle(0, 0, 1, 1, "over_ignores_goal");
    check("over_hold_score", 32'(player2_score), 32'(WIN));
    cycle(1, 0, 0, 0, "over_restart");
    check("restart_p1", 32'(player1_score), 32'd0);
    check("restart_p2", 32'(player2_score), 32'd0);
    check("restart_pulse", 32'(ball_reset), 32'd1);
    check("restart_not_over", 32'(game_over), 32'd0);

`ifdef AUTO_SERVE_EN
    for (int i = 0; i < SF - 1; i++) cycle(1, 0, 0, 1, "auto_wait");
    check("auto_not_yet", 32'(ball_run), 32'd0);
    cycle(1, 0, 0, 1, "auto_serve");
    check("auto_serve_run", 32'(ball_run), 32'd1);
`endif

    // Reset in the middle of a point hold-off.
    cycle(0, 0, 0, 0, "mid_rel");
    cycle(1, 0, 0, 0, "mid_serve");
    cycle(0, 0, 1, 0, "mid_goal2");
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1, "mid_ticks");
    do_reset(1'b0);
    cycle(0, 1, 0, 0, "idle_goal1");
    check("idle_goal_ignored", 32'(player1_score), 32'd0);
    for (int i = 0; i < PF; i++) cycle(0, 0, 0, 1, "idle_ticks");
    check("no_residual_pulse", 32'(ball_reset), 32'd0);

    // Random play against the model.
    st = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 1999) == 0) begin
        do_reset(st);
      end
      if ($urandom_range(0, 5) == 0) st = ~st;
      cycle(st, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
